// File: rtl/mips_mem_pkg.sv
// Shared constants and data-port direction encoding for the MIPS memory responder.
// Default address map: storage at 0, MMIO console/cycle words at the top of the 4 GB space.
package mips_mem_pkg;

    localparam int          DEF_DEPTH_WORDS  = 1024;
    localparam logic [31:0] DEF_BASE_ADDR    = 32'h0000_0000;
    localparam logic [31:0] DEF_CONSOLE_ADDR = 32'hFFFF_0000;
    localparam logic [31:0] DEF_CYCLE_ADDR   = 32'hFFFF_0004;

    // Matches the core's data_rd_wr polarity.
    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } rd_wr_e;

endpackage

// File: rtl/mips_mem_responder_if.sv
// Core <-> memory bus: instruction fetch, data read/write, preload and status.
// master = core/bench side, slave = memory responder.
interface mips_mem_responder_if;

    logic [31:0] instr_addr;
    logic [31:0] instr_in;
    logic [31:0] data_addr;
    logic        data_rd_wr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        err_misaligned;
    logic        err_range;
    logic        console_valid;
    logic [7:0]  console_data;

    modport master (
        output instr_addr, data_addr, data_rd_wr, data_out, load_en, load_addr, load_data,
        input  instr_in, data_in, err_misaligned, err_range, console_valid, console_data
    );

    modport slave (
        input  instr_addr, data_addr, data_rd_wr, data_out, load_en, load_addr, load_data,
        output instr_in, data_in, err_misaligned, err_range, console_valid, console_data
    );

endinterface

// File: rtl/mips_mem_decode.sv
// Byte address -> word index, storage-window hit, word alignment and MMIO register hits.
// Purely combinational; no latency, no backpressure.
module mips_mem_decode
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS  = DEF_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
    parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
    parameter logic [31:0] CYCLE_ADDR   = DEF_CYCLE_ADDR,
    localparam int         IDX_W        = $clog2(DEPTH_WORDS)
) (
    input  logic [31:0]      addr,
    output logic [IDX_W-1:0] index,
    output logic             in_range,
    output logic             aligned,
    output logic             is_console,
    output logic             is_cycle
);

    // 33-bit span so a window reaching the top of the address space still compares correctly.
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0] offset;

    assign offset     = addr - BASE_ADDR;
    assign in_range   = ({1'b0, offset} < SPAN);
    assign index      = offset[IDX_W+1:2];
    assign aligned    = (addr[1:0] == 2'b00);
    assign is_console = (addr == CONSOLE_ADDR);
    assign is_cycle   = (addr == CYCLE_ADDR);

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for the MIPS core: combinational fetch, 1-cycle registered data read, preload, sticky errors.
// No backpressure; optional MMIO console/cycle counter under `MIPS_MEM_MMIO_EN.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS  = DEF_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
    parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
    parameter logic [31:0] CYCLE_ADDR   = DEF_CYCLE_ADDR
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_mem_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] i_index, d_index, l_index;
    logic             i_in_range, d_in_range, l_in_range;
    logic             i_aligned, d_aligned, l_aligned;
    logic             i_console, d_console, l_console;
    logic             i_cycle, d_cycle, l_cycle;

    mips_mem_decode #(
        .DEPTH_WORDS(DEPTH_WORDS), .BASE_ADDR(BASE_ADDR),
        .CONSOLE_ADDR(CONSOLE_ADDR), .CYCLE_ADDR(CYCLE_ADDR)
    ) u_dec_instr (
        .addr(bus.instr_addr), .index(i_index), .in_range(i_in_range),
        .aligned(i_aligned), .is_console(i_console), .is_cycle(i_cycle)
    );

    mips_mem_decode #(
        .DEPTH_WORDS(DEPTH_WORDS), .BASE_ADDR(BASE_ADDR),
        .CONSOLE_ADDR(CONSOLE_ADDR), .CYCLE_ADDR(CYCLE_ADDR)
    ) u_dec_data (
        .addr(bus.data_addr), .index(d_index), .in_range(d_in_range),
        .aligned(d_aligned), .is_console(d_console), .is_cycle(d_cycle)
    );

    mips_mem_decode #(
        .DEPTH_WORDS(DEPTH_WORDS), .BASE_ADDR(BASE_ADDR),
        .CONSOLE_ADDR(CONSOLE_ADDR), .CYCLE_ADDR(CYCLE_ADDR)
    ) u_dec_load (
        .addr(bus.load_addr), .index(l_index), .in_range(l_in_range),
        .aligned(l_aligned), .is_console(l_console), .is_cycle(l_cycle)
    );

    // Decode outputs that some ports never need.
    logic unused_dec;
    assign unused_dec = ^{i_aligned, i_console, i_cycle, l_aligned, l_console, l_cycle,
                          d_console, d_cycle};

    logic core_rd;
    logic core_wr;
    logic mmio_hit;
    logic store_ok;

    // A preload in the same cycle pre-empts any core write, flags included.
    assign core_rd  = (bus.data_rd_wr == READ);
    assign core_wr  = !reset && (bus.data_rd_wr == WRITE) && !bus.load_en;
`ifdef MIPS_MEM_MMIO_EN
    assign mmio_hit = d_console || d_cycle;
`else
    assign mmio_hit = 1'b0;
`endif
    assign store_ok = core_wr && !mmio_hit && d_in_range && d_aligned;

    always_ff @(posedge clk) begin
        if (bus.load_en && l_in_range) begin
            mem[l_index] <= bus.load_data;
        end else if (store_ok) begin
            mem[d_index] <= bus.data_out;
        end
    end

    assign bus.instr_in = i_in_range ? mem[i_index] : 32'h0;

    logic [31:0] rd_word;
`ifdef MIPS_MEM_MMIO_EN
    logic [31:0] cycle_cnt;
`endif

    always_comb begin
        rd_word = d_in_range ? mem[d_index] : 32'h0;
`ifdef MIPS_MEM_MMIO_EN
        if (d_cycle) begin
            rd_word = cycle_cnt;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.data_in        <= 32'h0;
            bus.err_misaligned <= 1'b0;
            bus.err_range      <= 1'b0;
        end else begin
            if (core_rd) begin
                bus.data_in <= rd_word;
            end
            if (core_wr && !mmio_hit && !d_aligned) begin
                bus.err_misaligned <= 1'b1;
            end
            if (core_wr && !mmio_hit && !d_in_range) begin
                bus.err_range <= 1'b1;
            end
        end
    end

`ifdef MIPS_MEM_MMIO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt         <= 32'h0;
            bus.console_valid <= 1'b0;
            bus.console_data  <= 8'h0;
        end else begin
            cycle_cnt         <= cycle_cnt + 32'd1;
            bus.console_valid <= core_wr && d_console;
            if (core_wr && d_console) begin
                bus.console_data <= bus.data_out[7:0];
            end
        end
    end
`else
    assign bus.console_valid = 1'b0;
    assign bus.console_data  = 8'h0;
`endif

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Memory-side responder for the non-pipelined MIPS core's instruction and data buses.
- Serves the asynchronous instruction fetch and the one-cycle-latency data read/write port, in the timing the core's MEM and WB stages expect.
- Provides a preload port for boot/bench loading, sticky error flags, and optional memory-mapped console and cycle-counter registers.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words of storage; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be DEPTH_WORDS*4 aligned.
- CONSOLE_ADDR, 32'hFFFF_0000: MMIO console byte address (used only with the optional feature).
- CYCLE_ADDR, 32'hFFFF_0004: MMIO cycle-counter byte address (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- instr_addr  in  32  fetch byte address from the core.
- instr_in  out  32  fetched word to the core; combinational.
- data_addr  in  32  data byte address from the core.
- data_rd_wr  in  1  1 = read, 0 = write.
- data_out  in  32  write data from the core.
- data_in  out  32  read data to the core; registered.
- load_en  in  1  preload write strobe.
- load_addr  in  32  preload byte address.
- load_data  in  32  preload word.
- err_misaligned  out  1  sticky: a core write had data_addr[1:0] != 0.
- err_range  out  1  sticky: a core write fell outside the storage window (and outside MMIO when enabled).
- console_valid  out  1  one-cycle pulse: console write accepted.
- console_data  out  8  console byte.

Behaviour:
- Reset: synchronous, active-high; reset reset, clock clk.
  - Reset clears data_in = 0, err_misaligned = 0, err_range = 0, console_valid = 0, console_data = 0, cycle counter = 0.
  - Storage contents are NOT cleared.
  - All core writes are ignored while reset = 1; load writes still occur.
- Decode:
  - in_range = (addr - BASE_ADDR) < DEPTH_WORDS*4, unsigned.
  - index = (addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
  - aligned = (addr[1:0] == 0).
- Instruction port:
  - instr_in = mem[index(instr_addr)] combinationally when in range, else 32'h0 (NOP).
  - Low address bits are ignored.
  - A same-cycle write to the fetched word is not visible until after the clock edge.
- Data read (data_rd_wr = 1):
  - At each posedge, data_in <= mem[index(data_addr)] if in range, else 0.
  - Latency is exactly one cycle: the value is valid throughout the next cycle, aligned to the core's WB stage.
  - Misaligned reads truncate to the word and set no flag.
  - Out-of-range reads return 0 and set no flag. The core drives data_rd_wr = 1 with arbitrary ALU addresses on every non-store cycle, so reads must never flag.
- Data write (data_rd_wr = 0, reset = 0):
  - In range and aligned: mem[index] <= data_out at posedge.
  - Misaligned: write suppressed; err_misaligned <= 1.
  - Out of range: write suppressed; err_range <= 1.
  - A misaligned, out-of-range write sets both flags.
  - data_in holds its previous value during a write cycle.
- Read-after-write: a read of the same address in the following cycle returns the new data; no bypass is needed because the port is single-access per cycle.
- Preload:
  - load_en = 1 writes load_data to mem[index(load_addr)] at posedge if in range; otherwise it is silently dropped.
  - The address is word-truncated and no flags are set.
  - If load_en coincides with a core write to any address, load wins and the core write is dropped; no flag is set.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: MIPS_MEM_MMIO_EN.
- Defined:
  - Core write to CONSOLE_ADDR: console_valid pulses 1 for one cycle with console_data = data_out[7:0]; no storage write; no flag.
  - Core read of CYCLE_ADDR returns the cycle counter. The counter is 32-bit, increments every non-reset cycle, and wraps 0xFFFF_FFFF -> 0.
  - Write to CYCLE_ADDR: ignored, no flag.
- Undefined:
  - No counter is instantiated.
  - console_valid and console_data are tied to 0.
  - MMIO addresses decode as ordinary addresses: out of range unless inside the storage window.

Decomposition:
- Package mips_mem_pkg holds:
  - default BASE/CONSOLE/CYCLE address constants;
  - a read/write encoding enum (READ = 1, WRITE = 0) matching the core's data_rd_wr polarity.
- Sub-module mips_mem_decode: purely combinational address -> {index, in_range, aligned, is_console, is_cycle}.
  - Instantiated three times: instruction, data and load addresses.

Test Plan:
- Preload 0x8 <- 32'hDEAD_BEEF; set instr_addr = 0x8 -> instr_in = 32'hDEAD_BEEF in the same cycle; instr_addr = 0x1000 (out of range, depth 1024) -> instr_in = 0.
- Core write 0x10 <- 32'h1234_5678, then read 0x10 next cycle -> data_in = 32'h1234_5678 one cycle after the read address is presented, held the following cycle.
- Write to 0x13 -> err_misaligned = 1, mem[4] unchanged. Write to 0x2000 -> err_range = 1. Reads of 0x2000 and 0x13 -> no flags. Reset -> both flags 0.
- load_en with load_addr = 0x20 in the same cycle as a core write to 0x20 with 32'h1 -> mem[8] = load_data.
- Assert reset during a core write to 0x0 -> mem[0] unchanged, data_in = 0 after the edge.
- With MIPS_MEM_MMIO_EN: write 32'h41 to 0xFFFF_0000 -> one-cycle console_valid with console_data = 8'h41. After 10 cycles out of reset, read 0xFFFF_0004 -> data_in = 10 ± the documented one-cycle latency (exact value asserted).
